// File: rtl/dsc_mul_seq.sv
// Sequencer for the deterministic stochastic multiplier: accepts one operand
// triple, clears and runs the datapath until early shutoff or timeout, returns the count.
module dsc_mul_seq #(
  parameter int unsigned SNG_WIDTH  = 8,
  parameter int unsigned NUM_INPUTS = 3,
  localparam int unsigned ZW        = NUM_INPUTS * SNG_WIDTH,
  parameter int unsigned MAX_RUN    = 2**(NUM_INPUTS * SNG_WIDTH) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_a,
  input  logic [SNG_WIDTH-1:0] in_b,
  input  logic [SNG_WIDTH-1:0] in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ZW-1:0]        out_z,
  output logic                 out_timeout,
  output logic [ZW+1:0]        out_cycles,
  output logic                 busy,
  output logic [SNG_WIDTH-1:0] mul_a,
  output logic [SNG_WIDTH-1:0] mul_b,
  output logic [SNG_WIDTH-1:0] mul_c,
  output logic                 mul_rst,
  output logic                 mul_en,
  input  logic [ZW-1:0]        mul_z,
  input  logic                 mul_ov
);

  localparam int unsigned CW = ZW + 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_RUN - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, RESULT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] run_cnt;
  logic          ov_hit;

  // The datapath output is not yet valid in the first RUN cycle after its reset.
  assign ov_hit   = mul_ov && (run_cnt != '0);

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign mul_rst  = rst || (state == CLEAR);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = CLEAR;
      CLEAR:   next_state = RUN;
      RUN:     if (ov_hit || run_cnt == LAST_CNT) next_state = CAPTURE;
      CAPTURE: next_state = RESULT;
      RESULT:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run_cnt     <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      mul_en      <= 1'b0;
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;
      out_z       <= '0;
      out_cycles  <= '0;
    end else begin
      state  <= next_state;
      mul_en <= (next_state == RUN);
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a   <= in_a;
            mul_b   <= in_b;
            mul_c   <= in_c;
            run_cnt <= '0;
          end
        end
        RUN: begin
          // Counter freezes on the exit edge so CAPTURE sees the last RUN index.
          if (next_state == RUN) run_cnt <= run_cnt + 1'b1;
          else                   out_timeout <= !ov_hit;
        end
        CAPTURE: begin
          out_z      <= mul_z;
          out_cycles <= run_cnt + 1'b1;
          out_valid  <= 1'b1;
        end
        RESULT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Self-checking bench for dsc_mul_seq: stub datapath, transaction-level
// expectation model checked every cycle, plus directed literal checks.
module tb_dsc_mul_seq;

  localparam int unsigned SW = 8;
  localparam int unsigned NI = 3;
  localparam int unsigned ZW = SW * NI;
  localparam int unsigned MR = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [ZW-1:0] out_z;
  logic          out_timeout;
  logic [ZW+1:0] out_cycles;
  logic          busy;
  logic [SW-1:0] mul_a, mul_b, mul_c;
  logic          mul_rst, mul_en;
  logic [ZW-1:0] mul_z;
  logic          mul_ov;

  dsc_mul_seq #(.SNG_WIDTH(SW), .NUM_INPUTS(NI), .MAX_RUN(MR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_timeout(out_timeout), .out_cycles(out_cycles), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov)
  );

  always #5 clk = ~clk;

  // Stub datapath: counts enabled cycles since its reset, raises ov at a chosen index.
  int            stub_k = 0;
  int            ov_at = -1;
  logic          ov_stuck = 1'b0;
  logic [ZW-1:0] stub_z = '0;
  always @(posedge clk) begin
    if (mul_rst)     stub_k <= 0;
    else if (mul_en) stub_k <= stub_k + 1;
  end
  assign mul_ov = ov_stuck || (ov_at >= 0 && stub_k == ov_at);
  assign mul_z  = stub_z;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation described by accept edge T and final RUN index k.
  int            cyc = 0;
  bit            m_init = 0;
  bit            m_active = 0;
  int            m_t = 0, m_k = 0;
  logic          m_to = 1'b0;
  logic [SW-1:0] m_a = '0, m_b = '0, m_c = '0;
  logic [ZW-1:0] m_z = '0;

  initial begin : model
    int edge_no;
    forever begin
      @(posedge clk);
      edge_no = cyc;
      cyc = cyc + 1;
      if (rst) begin
        m_init = 1; m_active = 0;
        m_a = '0; m_b = '0; m_c = '0;
      end else if (m_active) begin
        if (out_ready && edge_no >= m_t + 4 + m_k) m_active = 0;
      end else if (in_valid) begin
        m_active = 1; m_t = edge_no;
        m_a = in_a; m_b = in_b; m_c = in_c; m_z = stub_z;
        if (ov_stuck) begin
          m_k = 1; m_to = 1'b0;
        end else if (ov_at >= 1 && ov_at <= int'(MR) - 1) begin
          m_k = ov_at; m_to = 1'b0;
        end else begin
          m_k = int'(MR) - 1; m_to = 1'b1;
        end
      end
    end
  end

  initial begin : compare
    int c;
    logic exp_ov;
    forever begin
      @(negedge clk);
      if (m_init) begin
        c = cyc;
        exp_ov = m_active && c >= m_t + 4 + m_k;
        chk("busy", busy, m_active);
        chk("in_ready", in_ready, !m_active && !rst);
        chk("mul_rst", mul_rst, rst || (m_active && c == m_t + 1));
        chk("mul_en", mul_en, m_active && c >= m_t + 2 && c <= m_t + 2 + m_k);
        chk("out_valid", out_valid, exp_ov);
        chk("mul_abc", {mul_a, mul_b, mul_c}, {m_a, m_b, m_c});
        if (exp_ov) begin
          chk("out_z", out_z, m_z);
          chk("out_cycles", out_cycles, m_k + 1);
          chk("out_timeout", out_timeout, m_to);
        end
      end
    end
  end

  task automatic drive_op(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] c);
    int w;
    @(posedge clk); #2;
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        chk("accept_wait", 0, 1);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input int exp_lat, input logic [ZW-1:0] exp_z,
                          input int exp_cyc, input logic exp_to);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_z"}, out_z, exp_z);
    chk({name, "_cycles"}, out_cycles, exp_cyc);
    chk({name, "_to"}, out_timeout, exp_to);
  endtask

  task automatic release_res;
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_ready", {in_ready, busy, out_valid}, 3'b100);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mul_rst", mul_rst, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_outs", {out_valid, busy, mul_en, out_z, out_cycles}, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {in_ready, busy, mul_rst, out_valid}, 4'b1000);

    // ov at k=5: out_valid 9 cycles after accept
    ov_at = 5; stub_z = 24'h00002A;
    drive_op(8'h11, 8'h22, 8'h33);
    wait_res("ov5", 9, 24'h00002A, 6, 1'b0);
    release_res();

    // ov held high from reset: k=0 blanked, capture at k=1
    ov_at = -1; ov_stuck = 1'b1; stub_z = 24'h123456;
    drive_op(8'h01, 8'h02, 8'h03);
    wait_res("blank", 5, 24'h123456, 2, 1'b0);
    release_res();
    ov_stuck = 1'b0;

    ov_at = -1; stub_z = 24'hFFFFFF;
    drive_op(8'h0A, 8'h0B, 8'h0C);
    wait_res("tmo", 19, 24'hFFFFFF, 16, 1'b1);
    release_res();

    // ov on the final RUN cycle wins over timeout
    ov_at = 15; stub_z = 24'h000100;
    drive_op(8'h0D, 8'h0E, 8'h0F);
    wait_res("ov15", 19, 24'h000100, 16, 1'b0);
    release_res();

    // ov only at k=0 is ignored, so the run times out
    ov_at = 0; stub_z = 24'h000005;
    drive_op(8'h10, 8'h20, 8'h30);
    wait_res("ov0", 19, 24'h000005, 16, 1'b1);
    release_res();

    // Backpressure with a new triple offered during RESULT
    ov_at = 3; stub_z = 24'hABCDEF;
    drive_op(8'h01, 8'h02, 8'h03);
    wait_res("bp", 7, 24'hABCDEF, 4, 1'b0);
    @(posedge clk); #2;
    ov_at = 2; stub_z = 24'h000777;
    in_valid = 1'b1; in_a = 8'h44; in_b = 8'h55; in_c = 8'h66;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_hold_z", out_z, 24'hABCDEF);
    chk("bp_hold_a", mul_a, 8'h01);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("bp_next_abc", {mul_a, mul_b, mul_c}, 24'h445566);
    wait_res("bp_next", 6, 24'h000777, 3, 1'b0);
    release_res();

    // Reset mid-RUN drops the operation
    ov_at = -1; stub_z = 24'h0000EE;
    drive_op(8'hFF, 8'hFF, 8'hFF);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_mul_rst", mul_rst, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_release", {in_ready, busy, out_valid, mul_rst, mul_en}, 5'b10000);
    chk("midrun_abc", {mul_a, mul_b, mul_c}, '0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrun_no_result", out_valid, 1'b0);

    // Early shutoff as a zero operand would give
    ov_at = 2; stub_z = '0;
    drive_op(8'h80, 8'hFF, 8'h00);
    wait_res("zero_op", 6, 24'h000000, 3, 1'b0);
    release_res();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
